// File: rtl/ttc_ctrl_seq4.sv
// APB master that configures a three-counter TTC and services its level interrupts.
// One FSM with registered outputs; each APB transfer is a SETUP/ACCESS pair tracked by access_q.
module ttc_ctrl_seq4 (
  input  logic        pclk4,
  input  logic        p_reset4,
  input  logic        start4,
  input  logic        stop4,
  input  logic [2:0]  cnt_en4,
  input  logic [4:0]  prescale4,
  input  logic [15:0] interval1_4,
  input  logic [15:0] interval2_4,
  input  logic [15:0] interval3_4,
  input  logic [2:0]  interrupt4,
  output logic        psel4,
  output logic        penable4,
  output logic        pwrite4,
  output logic [7:0]  paddr4,
  output logic [31:0] pwdata4,
  input  logic [31:0] prdata4,
  output logic        busy4,
  output logic        cfg_done4,
  output logic        evt_valid4,
  output logic [1:0]  evt_id4,
  output logic [5:0]  evt_data4
);

  // state | meaning
  // IDLE  | waiting for start4
  // CFG   | configuration writes, back to back
  // RUN   | watching enabled interrupts
  // SVC   | reading the interrupt register of one counter
  // GAP   | event pulse cycle, interrupts not sampled
  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_RUN,
    S_SVC,
    S_GAP
  } state_t;

  state_t      state_q;
  logic        access_q;
  logic        psel_q;
  logic        pwrite_q;
  logic [7:0]  paddr_q;
  logic [31:0] pwdata_q;
  logic        cfg_done_q;
  logic        evt_valid_q;
  logic [1:0]  evt_id_q;
  logic [5:0]  evt_data_q;
  logic        stop_q;
  logic [2:0]  cnt_en_q;
  logic [4:0]  prescale_q;
  logic [15:0] ival1_q;
  logic [15:0] ival2_q;
  logic [15:0] ival3_q;
  logic [1:0]  cnt_q;
  logic [1:0]  sub_q;
  logic [1:0]  rr_q;
  logic [1:0]  svc_q;

  logic        last_of_cnt_d;
  logic        last_step_d;
  logic [1:0]  cnt_d;
  logic [1:0]  sub_d;
  logic [3:0]  en_pad_d;
  logic [15:0] ival_d;
  logic [39:0] cfg_word_d;
  logic [2:0]  irq_m_d;
  logic        irq_hit_d;
  logic [1:0]  irq_pick_d;
  logic [1:0]  rr1_d;
  logic [1:0]  rr2_d;
  logic        unused_prdata;

  // {address, data} of configuration write 'sub' for counter n.
  function automatic logic [39:0] cfg_word(input logic [1:0] n, input logic [1:0] sub,
                                           input logic en, input logic [4:0] pre,
                                           input logic [15:0] ival);
    logic [7:0]  ofs;
    logic [7:0]  a;
    logic [31:0] d;
    ofs = {4'b0, n, 2'b00};
    if (!en) begin
      a = 8'h0C + ofs;
      d = 32'h1;
    end else begin
      case (sub)
        2'd0:    begin a = 8'h00 + ofs; d = {27'b0, pre};   end
        2'd1:    begin a = 8'h24 + ofs; d = {16'b0, ival};  end
        2'd2:    begin a = 8'h60 + ofs; d = 32'h1;          end
        default: begin a = 8'h0C + ofs; d = 32'h2;          end
      endcase
    end
    return {a, d};
  endfunction

  always_comb begin
    en_pad_d      = {1'b0, cnt_en_q};
    last_of_cnt_d = !en_pad_d[cnt_q] || (sub_q == 2'd3);
    last_step_d   = last_of_cnt_d && (cnt_q == 2'd2);
    cnt_d         = last_of_cnt_d ? cnt_q + 2'd1 : cnt_q;
    sub_d         = last_of_cnt_d ? 2'd0 : sub_q + 2'd1;
    case (cnt_d)
      2'd0:    ival_d = ival1_q;
      2'd1:    ival_d = ival2_q;
      default: ival_d = ival3_q;
    endcase
    cfg_word_d = cfg_word(cnt_d, sub_d, en_pad_d[cnt_d], prescale_q, ival_d);
  end

  // Round-robin search starting at rr_q.
  always_comb begin
    irq_m_d   = interrupt4 & cnt_en_q;
    irq_hit_d = |irq_m_d;
    rr1_d     = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
    rr2_d     = (rr_q == 2'd0) ? 2'd2 : rr_q - 2'd1;
    if (irq_m_d[rr_q])       irq_pick_d = rr_q;
    else if (irq_m_d[rr1_d]) irq_pick_d = rr1_d;
    else                     irq_pick_d = rr2_d;
  end

  always_ff @(posedge pclk4) begin
    if (p_reset4) begin
      state_q     <= S_IDLE;
      access_q    <= 1'b0;
      psel_q      <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      cfg_done_q  <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_data_q  <= '0;
      stop_q      <= 1'b0;
      cnt_en_q    <= '0;
      prescale_q  <= '0;
      ival1_q     <= '0;
      ival2_q     <= '0;
      ival3_q     <= '0;
      cnt_q       <= '0;
      sub_q       <= '0;
      rr_q        <= '0;
      svc_q       <= '0;
    end else begin
      cfg_done_q  <= 1'b0;
      evt_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start4) begin
            cnt_en_q            <= cnt_en4;
            prescale_q          <= prescale4;
            ival1_q             <= interval1_4;
            ival2_q             <= interval2_4;
            ival3_q             <= interval3_4;
            cnt_q               <= 2'd0;
            sub_q               <= 2'd0;
            stop_q              <= 1'b0;
            {paddr_q, pwdata_q} <= cfg_word(2'd0, 2'd0, cnt_en4[0], prescale4, interval1_4);
            psel_q              <= 1'b1;
            pwrite_q            <= 1'b1;
            access_q            <= 1'b0;
            state_q             <= S_CFG;
          end
        end
        S_CFG: begin
          if (stop4) stop_q <= 1'b1;
          if (!access_q) begin
            access_q <= 1'b1;
          end else if (stop_q || stop4) begin
            psel_q   <= 1'b0;
            access_q <= 1'b0;
            pwrite_q <= 1'b0;
            stop_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else if (last_step_d) begin
            psel_q     <= 1'b0;
            access_q   <= 1'b0;
            pwrite_q   <= 1'b0;
            cfg_done_q <= 1'b1;
            state_q    <= S_RUN;
          end else begin
            cnt_q               <= cnt_d;
            sub_q               <= sub_d;
            {paddr_q, pwdata_q} <= cfg_word_d;
            access_q            <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop4) begin
            state_q <= S_IDLE;
          end else if (irq_hit_d) begin
            svc_q    <= irq_pick_d;
            paddr_q  <= 8'h54 + {4'b0, irq_pick_d, 2'b00};
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            psel_q   <= 1'b1;
            access_q <= 1'b0;
            state_q  <= S_SVC;
          end
        end
        S_SVC: begin
          if (stop4) stop_q <= 1'b1;
          if (!access_q) begin
            access_q <= 1'b1;
          end else begin
            psel_q      <= 1'b0;
            access_q    <= 1'b0;
            evt_valid_q <= 1'b1;
            evt_id_q    <= svc_q + 2'd1;
            evt_data_q  <= prdata4[5:0];
            rr_q        <= (svc_q == 2'd2) ? 2'd0 : svc_q + 2'd1;
            if (stop_q || stop4) begin
              stop_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_GAP;
            end
          end
        end
        S_GAP: begin
          state_q <= stop4 ? S_IDLE : S_RUN;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign unused_prdata = ^prdata4[31:6];

  assign psel4      = psel_q;
  assign penable4   = access_q;
  assign pwrite4    = pwrite_q;
  assign paddr4     = paddr_q;
  assign pwdata4    = pwdata_q;
  assign busy4      = (state_q != S_IDLE);
  assign cfg_done4  = cfg_done_q;
  assign evt_valid4 = evt_valid_q;
  assign evt_id4    = evt_id_q;
  assign evt_data4  = evt_data_q;

endmodule

// File: tb/tb_ttc_ctrl_seq4.sv
// Bench for ttc_ctrl_seq4: directed scenarios plus randomized configurations and
// interrupt patterns, checked against a transaction-level model of the write list and service order.
module tb_ttc_ctrl_seq4;

  logic        pclk4 = 1'b0;
  logic        p_reset4, start4, stop4;
  logic [2:0]  cnt_en4;
  logic [4:0]  prescale4;
  logic [15:0] interval1_4, interval2_4, interval3_4;
  logic [2:0]  interrupt4;
  logic        psel4, penable4, pwrite4;
  logic [7:0]  paddr4;
  logic [31:0] pwdata4, prdata4;
  logic        busy4, cfg_done4, evt_valid4;
  logic [1:0]  evt_id4;
  logic [5:0]  evt_data4;

  ttc_ctrl_seq4 dut (
    .pclk4(pclk4), .p_reset4(p_reset4), .start4(start4), .stop4(stop4),
    .cnt_en4(cnt_en4), .prescale4(prescale4),
    .interval1_4(interval1_4), .interval2_4(interval2_4), .interval3_4(interval3_4),
    .interrupt4(interrupt4), .psel4(psel4), .penable4(penable4), .pwrite4(pwrite4),
    .paddr4(paddr4), .pwdata4(pwdata4), .prdata4(prdata4), .busy4(busy4),
    .cfg_done4(cfg_done4), .evt_valid4(evt_valid4), .evt_id4(evt_id4), .evt_data4(evt_data4)
  );

  always #5 pclk4 = ~pclk4;

  typedef struct {
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] data;
    int          cyc;
    logic        setup_ok;
  } xfer_t;
  typedef struct {
    int         cyc;
    logic [1:0] id;
    logic [5:0] data;
  } evt_t;

  xfer_t xq[$];
  evt_t  eq[$];
  int    done_q[$];
  int    cyc = 0;
  int    start_cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;
  int    mptr = 0;
  logic [2:0]  en_m;
  logic [7:0]  exp_addr[$];
  logic [31:0] exp_data[$];

  logic [7:0]  s_addr;
  logic        s_wr;
  logic [31:0] s_data;
  logic        s_valid = 1'b0;

  // Records each completed APB transfer and each pulse, tagged with the cycle it occupied.
  always @(posedge pclk4) begin : mon
    xfer_t x;
    evt_t  e;
    if (psel4 && penable4) begin
      x.addr = paddr4;
      x.wr = pwrite4;
      x.data = pwdata4;
      x.cyc = cyc;
      x.setup_ok = s_valid && (s_addr == paddr4) && (s_wr == pwrite4) && (s_data == pwdata4);
      xq.push_back(x);
    end
    s_valid = psel4 && !penable4;
    s_addr = paddr4;
    s_wr = pwrite4;
    s_data = pwdata4;
    if (cfg_done4) done_q.push_back(cyc);
    if (evt_valid4) begin
      e.cyc = cyc;
      e.id = evt_id4;
      e.data = evt_data4;
      eq.push_back(e);
    end
    if (start4 && !busy4 && !p_reset4) start_cyc = cyc;
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pclk4);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    p_reset4 = 1'b1;
    start4 = 1'b0;
    stop4 = 1'b0;
    interrupt4 = 3'b000;
    tick();
    p_reset4 = 1'b0;
    mptr = 0;
  endtask

  // Expected configuration write list, straight from the register map.
  function automatic void model_cfg(input logic [2:0] en, input logic [4:0] pre,
                                    input logic [15:0] i0, input logic [15:0] i1,
                                    input logic [15:0] i2);
    logic [15:0] iv[3];
    iv[0] = i0; iv[1] = i1; iv[2] = i2;
    exp_addr.delete();
    exp_data.delete();
    for (int n = 0; n < 3; n++) begin
      if (en[n]) begin
        exp_addr.push_back(8'(4*n));        exp_data.push_back({27'b0, pre});
        exp_addr.push_back(8'(8'h24 + 4*n)); exp_data.push_back({16'b0, iv[n]});
        exp_addr.push_back(8'(8'h60 + 4*n)); exp_data.push_back(32'h1);
        exp_addr.push_back(8'(8'h0C + 4*n)); exp_data.push_back(32'h2);
      end else begin
        exp_addr.push_back(8'(8'h0C + 4*n)); exp_data.push_back(32'h1);
      end
    end
  endfunction

  task automatic do_cfg(input logic [2:0] en, input logic [4:0] pre, input logic [15:0] i0,
                        input logic [15:0] i1, input logic [15:0] i2, input bit scramble);
    int n;
    xq.delete(); eq.delete(); done_q.delete();
    cnt_en4 = en; prescale4 = pre;
    interval1_4 = i0; interval2_4 = i1; interval3_4 = i2;
    en_m = en;
    model_cfg(en, pre, i0, i1, i2);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int t = 0; t < 60 && done_q.size() == 0; t++) begin
      if (scramble) begin
        cnt_en4 = 3'($urandom);
        prescale4 = 5'($urandom);
        interval1_4 = 16'($urandom);
        interval2_4 = 16'($urandom);
        interval3_4 = 16'($urandom);
      end
      tick();
    end
    n = exp_addr.size();
    check("cfg_write_count", xq.size(), n);
    check("cfg_done_seen", done_q.size(), 1);
    if (done_q.size() > 0) check("cfg_done_cycle", done_q[0] - start_cyc, 2*n + 1);
    for (int i = 0; i < n && i < xq.size(); i++) begin
      check($sformatf("cfg_addr[%0d]", i), xq[i].addr, exp_addr[i]);
      check($sformatf("cfg_data[%0d]", i), xq[i].data, exp_data[i]);
      check($sformatf("cfg_write[%0d]", i), xq[i].wr, 1);
      check($sformatf("cfg_setup[%0d]", i), xq[i].setup_ok, 1);
      check($sformatf("cfg_cycle[%0d]", i), xq[i].cyc - start_cyc, 2*(i+1));
    end
  endtask

  // Hold an interrupt pattern, then verify every service against round-robin order.
  task automatic run_irq(input logic [2:0] mask, input logic [31:0] prd, input int hold);
    logic [2:0] m;
    int k;
    xq.delete(); eq.delete();
    interrupt4 = mask;
    prdata4 = prd;
    repeat (hold) tick();
    interrupt4 = 3'b000;
    repeat (8) tick();
    m = mask & en_m;
    if (m == 3'b000) begin
      check("svc_none", xq.size(), 0);
    end else begin
      check("svc_some", xq.size() > 0, 1);
      check("svc_evt_count", eq.size(), xq.size());
      foreach (xq[i]) begin
        k = -1;
        for (int j = 0; j < 3; j++)
          if (k < 0 && m[(mptr + j) % 3]) k = (mptr + j) % 3;
        check($sformatf("svc_addr[%0d]", i), xq[i].addr, 8'h54 + 4*k);
        check($sformatf("svc_rd[%0d]", i), {xq[i].wr, xq[i].data}, 0);
        check($sformatf("svc_setup[%0d]", i), xq[i].setup_ok, 1);
        if (i < eq.size()) begin
          check($sformatf("evt_id[%0d]", i), eq[i].id, k + 1);
          check($sformatf("evt_data[%0d]", i), eq[i].data, prd[5:0]);
          check($sformatf("evt_cycle[%0d]", i), eq[i].cyc - xq[i].cyc, 1);
        end
        if (i > 0) check($sformatf("svc_spacing[%0d]", i), xq[i].cyc - xq[i-1].cyc, 4);
        mptr = (k + 1) % 3;
      end
    end
  endtask

  logic [7:0] a27[12];
  logic [7:0] a28[6];

  initial begin
    a27 = '{8'h00, 8'h24, 8'h60, 8'h0C, 8'h04, 8'h28, 8'h64, 8'h10, 8'h08, 8'h2C, 8'h68, 8'h14};
    a28 = '{8'h0C, 8'h04, 8'h28, 8'h64, 8'h10, 8'h14};
    p_reset4 = 1'b1; start4 = 1'b0; stop4 = 1'b0;
    cnt_en4 = '0; prescale4 = '0; interval1_4 = '0; interval2_4 = '0; interval3_4 = '0;
    interrupt4 = '0; prdata4 = '0;
    tick(); tick();
    p_reset4 = 1'b0;
    check("reset_outputs",
          {psel4, penable4, pwrite4, paddr4, pwdata4, busy4, cfg_done4, evt_valid4, evt_id4, evt_data4}, 0);

    // stop in IDLE is ignored; reset wins over a simultaneous start
    stop4 = 1'b1; tick(); stop4 = 1'b0;
    check("idle_stop_busy", busy4, 0);
    p_reset4 = 1'b1; start4 = 1'b1; tick(); p_reset4 = 1'b0; start4 = 1'b0;
    check("rst_prio_busy", {busy4, psel4}, 0);
    tick();
    check("rst_prio_busy_next", busy4, 0);

    // full configuration, fixed values
    do_reset();
    do_cfg(3'b111, 5'h03, 16'h0010, 16'h0020, 16'h0030, 1'b0);
    for (int i = 0; i < 12 && i < xq.size(); i++) check($sformatf("r27_addr[%0d]", i), xq[i].addr, a27[i]);

    // interrupts 1 and 3 held: services alternate 1, 3
    run_irq(3'b101, 32'h1, 10);
    check("r29_two_reads", xq.size() >= 2, 1);
    if (xq.size() >= 2 && eq.size() >= 2) begin
      check("r29_addr0", xq[0].addr, 8'h54);
      check("r29_addr1", xq[1].addr, 8'h5C);
      check("r29_id0", eq[0].id, 2'd1);
      check("r29_id1", eq[1].id, 2'd3);
    end

    // stop during SVC SETUP: read completes, event fires, then idle and deaf
    for (int t = 0; t < 12 && !(psel4 && !penable4); t++) begin
      interrupt4 = 3'b010;
      tick();
    end
    xq.delete(); eq.delete();
    interrupt4 = 3'b010;
    prdata4 = 32'h2A;
    for (int t = 0; t < 12 && !(psel4 && !penable4); t++) tick();
    check("r31_in_setup", {psel4, penable4}, 2'b10);
    stop4 = 1'b1; tick(); stop4 = 1'b0;
    repeat (3) tick();
    check("r31_reads", xq.size(), 1);
    check("r31_evts", eq.size(), 1);
    if (eq.size() > 0) check("r31_evt", {eq[0].id, eq[0].data}, {2'd2, 6'h2A});
    check("r31_idle", busy4, 0);
    xq.delete();
    repeat (10) tick();
    check("r31_ignored", xq.size(), 0);
    interrupt4 = 3'b000;

    // single counter enabled; later start pulse in RUN is ignored
    do_reset();
    do_cfg(3'b010, 5'h11, 16'h1234, 16'hBEEF, 16'h5678, 1'b0);
    for (int i = 0; i < 6 && i < xq.size(); i++) check($sformatf("r28_addr[%0d]", i), xq[i].addr, a28[i]);
    xq.delete();
    cnt_en4 = 3'b111;
    start4 = 1'b1; tick(); start4 = 1'b0;
    repeat (4) tick();
    check("run_start_ignored", {busy4, 32'(xq.size())}, {1'b1, 32'd0});
    run_irq(3'b111, 32'h3F, 9);

    // no counters enabled
    do_reset();
    do_cfg(3'b000, 5'h1F, 16'h1, 16'h2, 16'h3, 1'b0);

    // reset during ACCESS of the 5th write, then a clean restart
    do_reset();
    cnt_en4 = 3'b111; prescale4 = 5'h03;
    interval1_4 = 16'h0010; interval2_4 = 16'h0020; interval3_4 = 16'h0030;
    start4 = 1'b1; tick(); start4 = 1'b0;
    repeat (9) tick();
    check("r30_access5", {psel4, penable4, paddr4}, {1'b1, 1'b1, 8'h04});
    p_reset4 = 1'b1; tick(); p_reset4 = 1'b0;
    check("r30_after_reset",
          {psel4, penable4, pwrite4, paddr4, pwdata4, busy4, cfg_done4, evt_valid4, evt_id4, evt_data4}, 0);
    tick();
    do_cfg(3'b111, 5'h03, 16'h0010, 16'h0020, 16'h0030, 1'b0);
    if (xq.size() > 0) check("r30_restart_addr", xq[0].addr, 8'h00);

    // randomized configurations (inputs scrambled after start) and interrupt patterns
    for (int it = 0; it < 6; it++) begin
      do_reset();
      do_cfg(3'($urandom), 5'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
      run_irq(3'($urandom), $urandom, $urandom_range(4, 14));
      run_irq(3'($urandom), $urandom, $urandom_range(4, 14));
      check("run_busy", busy4, 1);
      stop4 = 1'b1; tick(); stop4 = 1'b0;
      check("run_stop_idle", busy4, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ttc_ctrl_seq4.md
TTC_CTRL_SEQ4 -- requirements
Module: ttc_ctrl_seq4

Interface
REQ-001 SHALL provide a single clock and a synchronous, active-high reset, named pclk4 and p_reset4 respectively.
REQ-002 SHALL have ports (name dir width meaning):
- pclk4 in 1: clock.
- p_reset4 in 1: synchronous active-high reset.
- start4 in 1: pulse; begin configuration.
- stop4 in 1: pulse; leave RUN.
- cnt_en4 in 3: bit n = counter n+1 used.
- prescale4 in 5: written to every clock-control register.
- interval1_4, interval2_4, interval3_4 in 16 each: interval values.
- interrupt4 in 3: TTC level interrupts [3:1].
- psel4, penable4, pwrite4 out 1 each: APB master controls.
- paddr4 out 8: APB address.
- pwdata4 out 32: APB write data.
- prdata4 in 32: APB read data.
- busy4 out 1: not IDLE.
- cfg_done4 out 1: one-cycle pulse at end of configuration.
- evt_valid4 out 1: one-cycle pulse per serviced interrupt.
- evt_id4 out 2: counter serviced, 1..3.
- evt_data4 out 6: prdata4[5:0] of interrupt read.

Function
REQ-003 SHALL use TTC map, n=0..2: clk ctrl 0x00+4n, cnt ctrl 0x0C+4n, interval 0x24+4n, int reg 0x54+4n (clear-on-read), int enable 0x60+4n.
REQ-004 SHALL run every APB transfer in exactly 2 cycles: SETUP (psel4=1, penable4=0), then ACCESS (psel4=1, penable4=1); no wait states.
REQ-005 SHALL hold paddr4, pwrite4 and pwdata4 stable across both cycles, and drive pwdata4=0 on reads.
REQ-006 SHALL capture prdata4 on the clock edge ending ACCESS.
REQ-007 SHALL drive psel4 and penable4 to 0 in every non-transfer cycle.
REQ-008 SHALL implement FSM states IDLE, CFG, RUN, SVC, GAP; APB phase is a sub-state flag.
REQ-009 IDLE: start4=1 -> CFG with step=0; start4 ignored in every other state.
REQ-010 CFG, enabled counter n (ascending n), SHALL write in order:
- clk ctrl = {27'b0, prescale4}
- interval = {16'b0, intervalN}
- int enable = 0x01
- cnt ctrl = 0x02
REQ-011 CFG, disabled counter n, SHALL issue a single write, cnt ctrl = 0x01.
REQ-012 CFG SHALL make transfers back-to-back with no idle cycle between them.
REQ-013 After the last CFG write, the FSM SHALL assert cfg_done4 for one cycle in the first RUN cycle.
REQ-014 cnt_en4=3'b000 SHALL produce exactly 3 writes, then RUN.
REQ-015 RUN: if interrupt4[k]=1 for any enabled k, the FSM SHALL go to SVC and read int reg of k.
REQ-016 Arbitration SHALL be round-robin, searching from the counter after the last serviced one; the first search after reset starts at counter 1.
REQ-017 After an SVC read, the FSM SHALL pulse evt_valid4 with evt_id4=k and evt_data4=captured[5:0] in the following cycle, the GAP cycle.
REQ-018 GAP SHALL last exactly one cycle, with interrupt4 not sampled, then return to RUN.
REQ-019 interrupt4 bits of disabled counters SHALL be ignored.
REQ-020 stop4 in RUN SHALL return the FSM to IDLE next cycle.
REQ-021 stop4 in CFG or SVC SHALL be latched; the FSM SHALL go to IDLE after the current transfer completes. In SVC, evt_valid4 SHALL still fire.
REQ-022 stop4 in IDLE SHALL be ignored.
REQ-023 cnt_en4, prescale4 and intervals SHALL be registered on the start4 cycle; later changes SHALL have no effect until the next start.
REQ-024 busy4 SHALL be 1 in all states except IDLE.

Reset
REQ-025 p_reset4=1 at a clock edge SHALL force, the next cycle, regardless of state or mid-transfer:
- state IDLE
- all outputs 0
- round-robin pointer to counter 1
- stop latch cleared
- step counter 0
REQ-026 Reset SHALL take priority over start4 and stop4 in the same cycle.

Verification
REQ-027 SHALL cover: cnt_en4=3'b111, prescale4=5'h03, intervals 0x0010/0x0020/0x0030, start4 pulse -> 12 writes in 24 consecutive cycles:
- addresses 00,24,60,0C,04,28,64,10,08,2C,68,14
- cfg_done4 on cycle 25
REQ-028 SHALL cover: cnt_en4=3'b010 -> writes 0x0C=1, then the 4 writes for counter 2, then 0x14=1; total 6 writes.
REQ-029 SHALL cover: RUN, interrupt4=3'b101 held, prdata4=0x01 -> reads 0x54, then 0x5C, in round-robin order; two evt_valid4 pulses with ids 1 and 3; one GAP cycle between them.
REQ-030 SHALL cover: p_reset4 asserted during ACCESS of the 5th CFG write -> next cycle psel4=0, busy4=0; a new start4 repeats the full sequence from address 0x00.
REQ-031 SHALL cover: stop4 during SVC SETUP -> transfer completes, evt_valid4 pulses, then IDLE; interrupt4 ignored afterwards.
